instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit.sv | 133 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
// Holds the fetch PC, reads one instruction word per cycle from a combinational
// instruction memory and queues {pc, instr} pairs in a 2-entry FIFO for decode.
// A redirect flushes the queue and reloads the PC.
// Optional feature macro: IFU_MISALIGN_CHECK_EN. When defined, a redirect to a
// misaligned target raises a sticky fetch_err and halts fetching until an aligned
// redirect or a reset. When undefined, redirect targets are word-aligned by
// dropping the two low bits and fetch_err is tied low.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready,
    output logic        fetch_err
);

    logic [31:0] pc;
    logic [1:0]  count;
    logic [31:0] head_pc;
    logic [31:0] head_instr;
    logic [31:0] tail_pc;
    logic [31:0] tail_instr;

    logic        fetch_en;
    logic        bad_redirect;
    logic [31:0] target;
    logic        pop;
    logic        push;

`ifdef IFU_MISALIGN_CHECK_EN
    logic halted;

    assign target       = redirect_pc;
    assign bad_redirect = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign fetch_en     = !halted;
    assign fetch_err    = halted;

    // Sticky halt: set by a misaligned redirect, cleared by an aligned one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted <= 1'b0;
        end else if (redirect_valid) begin
            halted <= (redirect_pc[1:0] != 2'b00);
        end
    end
`else
    logic unused_align_bits;

    assign unused_align_bits = ^redirect_pc[1:0];
    assign target            = {redirect_pc[31:2], 2'b00};
    assign bad_redirect      = 1'b0;
    assign fetch_en          = 1'b1;
    assign fetch_err         = 1'b0;
`endif

    assign imem_addr = pc;
    assign if_valid  = (count != 2'd0);
    assign if_pc     = head_pc;
    assign if_instr  = head_instr;

    // Handshake: a pop is counted even when a redirect flushes the same cycle.
    always_comb begin
        pop  = if_valid && id_ready;
        push = fetch_en && !redirect_valid && ((count != 2'd2) || pop);
    end

    // Fetch PC: a good redirect wins, otherwise advance by one word on each push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            if (!bad_redirect) begin
                pc <= target;
            end
        end else if (push) begin
            pc <= pc + 32'd4;
        end
    end

    // Two-entry queue kept as head/tail registers; the head always feeds decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= 2'd0;
            head_pc    <= 32'd0;
            head_instr <= 32'd0;
            tail_pc    <= 32'd0;
            tail_instr <= 32'd0;
        end else if (redirect_valid) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b11: begin
                    if (count == 2'd2) begin
                        head_pc    <= tail_pc;
                        head_instr <= tail_instr;
                        tail_pc    <= pc;
                        tail_instr <= imem_rdata;
                    end else begin
                        head_pc    <= pc;
                        head_instr <= imem_rdata;
                    end
                end
                2'b10: begin
                    if (count == 2'd0) begin
                        head_pc    <= pc;
                        head_instr <= imem_rdata;
                    end else begin
                        tail_pc    <= pc;
                        tail_instr <= imem_rdata;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head_pc    <= tail_pc;
                    head_instr <= tail_instr;
                    count      <= count - 2'd1;
                end
                default: begin
                    count <= count;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit
// Randomized and directed stimulus for instruction_fetch_unit, checked each cycle
// against a queue-based model of the fetch stream. Honours IFU_MISALIGN_CHECK_EN.
module tb_instruction_fetch_unit;

`ifdef IFU_MISALIGN_CHECK_EN
    localparam bit MISALIGN_EN = 1'b1;
`else
    localparam bit MISALIGN_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        fetch_err;

    int assertCount = 0;
    int failCount   = 0;
    bit checkEn     = 1'b0;

    // Model state: queued PCs toward decode, next fetch address, sticky error.
    logic [31:0] mQ[$];
    logic [31:0] mFetchPc = 32'h0;
    bit          mErr     = 1'b0;

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .id_ready       (id_ready),
        .fetch_err      (fetch_err)
    );

    // Instruction memory contents: two fixed words at 0 and 4, a hash elsewhere.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_00B3;
        if (a == 32'h4) return 32'h0000_0233;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign imem_rdata = memWord(imem_addr);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive inputs just after a falling edge, then let one rising edge act on them.
    task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic rdy);
        #1;
        redirect_valid = rv;
        redirect_pc    = rpc;
        id_ready       = rdy;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulseReset();
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Reference model: advances the expected fetch stream on each rising edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mQ.delete();
            mFetchPc = 32'h0;
            mErr     = 1'b0;
        end else if (redirect_valid) begin
            mQ.delete();
            if (MISALIGN_EN && (redirect_pc[1:0] != 2'b00)) begin
                mErr = 1'b1;
            end else begin
                mFetchPc = redirect_pc & ~32'h3;
                mErr     = 1'b0;
            end
        end else begin
            if ((mQ.size() > 0) && id_ready) void'(mQ.pop_front());
            if (!mErr && (mQ.size() < 2)) begin
                mQ.push_back(mFetchPc);
                mFetchPc = mFetchPc + 32'd4;
            end
        end
    end

    // Compare DUT outputs with the model on every falling edge.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("imem_addr", imem_addr, mFetchPc);
            checkOutput("if_valid", {31'b0, if_valid}, {31'b0, (mQ.size() > 0)});
            checkOutput("fetch_err", {31'b0, fetch_err}, {31'b0, mErr});
            checkOutput("no_x_outputs", {31'b0, $isunknown({if_pc, if_instr, imem_addr})}, 32'h0);
            if (mQ.size() > 0) begin
                checkOutput("if_pc", if_pc, mQ[0]);
                checkOutput("if_instr", if_instr, memWord(mQ[0]));
            end
        end
    end

    // Directed scenarios with literal expectations, then a randomized run.
    initial begin
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;

        rst_n          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b1;
        #2 rst_n = 1'b0;
        #1 checkEn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_if_valid", {31'b0, if_valid}, 32'h0);
        checkOutput("rst_imem_addr", imem_addr, 32'h0);
        checkOutput("rst_fetch_err", {31'b0, fetch_err}, 32'h0);
        checkOutput("rst_if_pc", if_pc, 32'h0);
        checkOutput("rst_if_instr", if_instr, 32'h0);

        // First two fetches after reset release.
        #1 rst_n = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("c1_if_valid", {31'b0, if_valid}, 32'h1);
        checkOutput("c1_if_pc", if_pc, 32'h0);
        checkOutput("c1_if_instr", if_instr, 32'h0000_00B3);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("c2_if_pc", if_pc, 32'h4);
        checkOutput("c2_if_instr", if_instr, 32'h0000_0233);

        // Stall decode from reset: queue fills with 0,4 and the PC parks at 8.
        id_ready = 1'b0;
        pulseReset();
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("stall_if_pc", if_pc, 32'h0);
        checkOutput("stall_imem_addr", imem_addr, 32'h8);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("drain_if_pc", if_pc, 32'h4);
        checkOutput("drain_imem_addr", imem_addr, 32'hC);

        // Redirect while holding 4 and 8.
        applyStimulus(1'b1, 32'h10, 1'b1);
        checkOutput("redir_if_valid", {31'b0, if_valid}, 32'h0);
        checkOutput("redir_imem_addr", imem_addr, 32'h10);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("redir_if_pc", if_pc, 32'h10);

        // Fill, then stream one instruction per cycle through a full queue.
        applyStimulus(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1);
            checkOutput("stream_if_pc", if_pc, 32'h14 + 32'(4 * i));
            checkOutput("stream_imem_addr", imem_addr, 32'h1C + 32'(4 * i));
        end

        // PC wraps from the top of the address space.
        applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1);
        checkOutput("wrap_imem_addr_top", imem_addr, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
        checkOutput("wrap_imem_addr", imem_addr, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("wrap_next_instr", if_instr, 32'h0000_00B3);

        // Back-to-back redirects: the last one wins.
        applyStimulus(1'b1, 32'h100, 1'b1);
        applyStimulus(1'b1, 32'h200, 1'b1);
        checkOutput("b2b_imem_addr", imem_addr, 32'h200);
        checkOutput("b2b_if_valid", {31'b0, if_valid}, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("b2b_if_pc", if_pc, 32'h200);

        // Misaligned redirect target.
        applyStimulus(1'b1, 32'h12, 1'b1);
        if (MISALIGN_EN) begin
            checkOutput("mis_fetch_err", {31'b0, fetch_err}, 32'h1);
            checkOutput("mis_imem_addr", imem_addr, 32'h204);
            for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1);
            checkOutput("mis_halt_valid", {31'b0, if_valid}, 32'h0);
            checkOutput("mis_halt_err", {31'b0, fetch_err}, 32'h1);
            applyStimulus(1'b1, 32'h20, 1'b1);
            checkOutput("mis_clear_err", {31'b0, fetch_err}, 32'h0);
            applyStimulus(1'b0, 32'h0, 1'b1);
            checkOutput("mis_resume_pc", if_pc, 32'h20);
        end else begin
            checkOutput("align_fetch_err", {31'b0, fetch_err}, 32'h0);
            checkOutput("align_imem_addr", imem_addr, 32'h10);
            applyStimulus(1'b0, 32'h0, 1'b1);
            checkOutput("align_if_pc", if_pc, 32'h10);
        end

        // Randomized traffic with occasional resets, redirects and wrap targets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                pulseReset();
            end
            rv  = ($urandom_range(0, 19) == 0);
            rpc = $urandom;
            if ($urandom_range(0, 9) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
            if (!MISALIGN_EN || ($urandom_range(0, 3) != 0)) rpc[1:0] = 2'b00;
            rdy = ($urandom_range(0, 3) != 0);
            applyStimulus(rv, rpc, rdy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
